// File: rtl/la_oa211_bist.sv
// la_oa211_bist: built-in self-test for an oa211 cell, z = (a0 | a1) & b0 & c0.
//
// The block steps the four gate inputs through all 16 patterns, PASSES times
// over. Each cycle it checks the gate response against the ideal function and
// reports the result. The gate under test is combinational and wired directly:
// a0/a1/b0/c0 drive the gate, and z returns within the same cycle.
//
// Parameters:
//   PROP    implementation property string (no behavioural effect)
//   PASSES  number of full 16-pattern sweeps per run, 1..255
//
// Ports:
//   clk           clock, rising edge
//   nreset        asynchronous active-low reset
//   start         level-sampled run request, honoured only when idle
//   a0,a1,b0,c0   drive to the gate under test (pat[0..3])
//   z             gate response
//   busy          high while sweeping
//   done          one-cycle pulse when a run completes
//   pass          result of the last completed run
//   fail_count    saturating mismatch count of the current/last run
//   fail_valid    at least one mismatch in the current/last run
//   fail_pattern  first mismatching pattern (only with LA_OA211_BIST_CAPTURE_EN)
//
// Optional feature macro: LA_OA211_BIST_CAPTURE_EN adds the fail_pattern
// port and its capture register.

module la_oa211_bist #(
  parameter string PROP   = "DEFAULT",
  parameter int    PASSES = 1
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       start,
  output logic       a0,
  output logic       a1,
  output logic       b0,
  output logic       c0,
  input  logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_count,
`ifdef LA_OA211_BIST_CAPTURE_EN
  output logic [3:0] fail_pattern,
`endif
  output logic       fail_valid
);

  // PROP is informational only; this empty branch just references it.
  if (PROP == "") begin : g_prop_unset
  end

  localparam logic [7:0] LAST_SWEEP = 8'(PASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e     state_q;
  logic [3:0] pat_q;
  logic [7:0] sweep_q;
  logic [7:0] fail_cnt_q;
  logic [7:0] fail_cnt_d;
  logic       fail_vld_q;
  logic       pass_q;
  logic       busy_q;
  logic       done_q;
  logic       exp_d;
  logic       mism_d;
  logic       last_d;
`ifdef LA_OA211_BIST_CAPTURE_EN
  logic [3:0] fail_pat_q;
`endif

  always_comb begin
    exp_d      = (pat_q[0] | pat_q[1]) & pat_q[2] & pat_q[3];
    mism_d     = (z != exp_d);
    fail_cnt_d = fail_cnt_q;
    if (mism_d && (fail_cnt_q != 8'hFF)) begin
      fail_cnt_d = fail_cnt_q + 8'd1;
    end
    last_d     = (pat_q == 4'hF) && (sweep_q == LAST_SWEEP);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= S_IDLE;
      pat_q      <= 4'd0;
      sweep_q    <= 8'd0;
      fail_cnt_q <= 8'd0;
      fail_vld_q <= 1'b0;
      pass_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef LA_OA211_BIST_CAPTURE_EN
      fail_pat_q <= 4'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q    <= S_RUN;
            busy_q     <= 1'b1;
            pat_q      <= 4'd0;
            sweep_q    <= 8'd0;
            fail_cnt_q <= 8'd0;
            fail_vld_q <= 1'b0;
            pass_q     <= 1'b0;
`ifdef LA_OA211_BIST_CAPTURE_EN
            fail_pat_q <= 4'd0;
`endif
          end
        end
        S_RUN: begin
          if (mism_d) begin
            fail_cnt_q <= fail_cnt_d;
            fail_vld_q <= 1'b1;
`ifdef LA_OA211_BIST_CAPTURE_EN
            if (!fail_vld_q) begin
              fail_pat_q <= pat_q;
            end
`endif
          end
          // pat wraps 15 -> 0, so the drive outputs read 0 again once the run ends.
          pat_q <= pat_q + 4'd1;
          if (pat_q == 4'hF) begin
            sweep_q <= sweep_q + 8'd1;
          end
          if (last_d) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (fail_cnt_d == 8'd0);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a0         = pat_q[0];
  assign a1         = pat_q[1];
  assign b0         = pat_q[2];
  assign c0         = pat_q[3];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_count = fail_cnt_q;
  assign fail_valid = fail_vld_q;
`ifdef LA_OA211_BIST_CAPTURE_EN
  assign fail_pattern = fail_pat_q;
`endif

endmodule

// File: tb/tb_la_oa211_bist.sv
// Testbench for la_oa211_bist: three instances (PASSES = 1, 4, 20), each with
// a selectable gate model on z (ideal, stuck-at-0, stuck-at-1, OR->AND fault).
// Stimulus pushes expected drive patterns and run results into queues; a
// negedge monitor pops and compares whenever a DUT is busy or pulses done.

module tb_la_oa211_bist;

  logic       clk = 1'b0;
  logic       nreset;
  logic [2:0] start_v;
  logic [2:0] z_v;
  logic [2:0] a0_v, a1_v, b0_v, c0_v;
  logic [2:0] busy_v, done_v, pass_v, fv_v;
  logic [7:0] fc_v   [3];
  logic [3:0] fp_v   [3];
  logic [1:0] mode_v [3];

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int         inst;
    int         done_cyc;
    logic       pass;
    logic [7:0] fc;
    logic       fv;
    logic [3:0] fp;
  } res_t;

  typedef struct {
    int         inst;
    logic [3:0] pat;
  } drv_t;

  res_t resq[$];
  drv_t drvq[$];

  localparam logic [1:0] M_IDEAL = 2'd0;
  localparam logic [1:0] M_SA0   = 2'd1;
  localparam logic [1:0] M_SA1   = 2'd2;
  localparam logic [1:0] M_AND   = 2'd3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic gate(input logic [1:0] m, input logic a0, input logic a1,
                                input logic b0, input logic c0);
    case (m)
      M_IDEAL: gate = (a0 | a1) & b0 & c0;
      M_SA0:   gate = 1'b0;
      M_SA1:   gate = 1'b1;
      default: gate = (a0 & a1) & b0 & c0;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int P = (g == 0) ? 1 : (g == 1) ? 4 : 20;
    assign z_v[g] = gate(mode_v[g], a0_v[g], a1_v[g], b0_v[g], c0_v[g]);
`ifndef LA_OA211_BIST_CAPTURE_EN
    assign fp_v[g] = 4'd0;
`endif
    la_oa211_bist #(.PROP("DEFAULT"), .PASSES(P)) u_dut (
      .clk        (clk),
      .nreset     (nreset),
      .start      (start_v[g]),
      .a0         (a0_v[g]),
      .a1         (a1_v[g]),
      .b0         (b0_v[g]),
      .c0         (c0_v[g]),
      .z          (z_v[g]),
      .busy       (busy_v[g]),
      .done       (done_v[g]),
      .pass       (pass_v[g]),
      .fail_count (fc_v[g]),
`ifdef LA_OA211_BIST_CAPTURE_EN
      .fail_pattern (fp_v[g]),
`endif
      .fail_valid (fv_v[g])
    );
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares drive patterns while busy and results on done.
  always @(negedge clk) begin
    logic [3:0] pat;
    drv_t       d;
    res_t       r;
    if (nreset) begin
      for (int g = 0; g < 3; g++) begin
        pat = {c0_v[g], b0_v[g], a1_v[g], a0_v[g]};
        if (busy_v[g]) begin
          if (drvq.size() > 0 && drvq[0].inst == g) begin
            d = drvq.pop_front();
            chk($sformatf("drive[%0d]", g), pat, d.pat);
          end else begin
            chk($sformatf("stray_busy[%0d]", g), busy_v[g], 0);
          end
        end else begin
          chk($sformatf("idle_drive[%0d]", g), pat, 0);
        end
        if (done_v[g]) begin
          if (resq.size() > 0 && resq[0].inst == g) begin
            r = resq.pop_front();
            chk($sformatf("done_cycle[%0d]", g), cyc, r.done_cyc);
            chk($sformatf("pass[%0d]", g), pass_v[g], r.pass);
            chk($sformatf("fail_count[%0d]", g), fc_v[g], r.fc);
            chk($sformatf("fail_valid[%0d]", g), fv_v[g], r.fv);
`ifdef LA_OA211_BIST_CAPTURE_EN
            chk($sformatf("fail_pattern[%0d]", g), fp_v[g], r.fp);
`endif
            chk($sformatf("busy_in_done[%0d]", g), busy_v[g], 0);
          end else begin
            chk($sformatf("stray_done[%0d]", g), done_v[g], 0);
          end
        end
      end
    end
  end

  task automatic push_run(input int g, input int p, input int s, input bit with_res,
                          input logic ps, input logic [7:0] fc, input logic fv,
                          input logic [3:0] fp);
    drv_t d;
    res_t r;
    for (int k = 0; k < 16 * p; k++) begin
      d.inst = g;
      d.pat  = 4'(k);
      drvq.push_back(d);
    end
    if (with_res) begin
      r.inst     = g;
      r.done_cyc = s + 16 * p;
      r.pass     = ps;
      r.fc       = fc;
      r.fv       = fv;
      r.fp       = fp;
      resq.push_back(r);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((resq.size() > 0 || drvq.size() > 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("queue_left", resq.size() + drvq.size(), 0);
    resq.delete();
    drvq.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic run(input int g, input int p, input logic [1:0] m, input logic ps,
                     input logic [7:0] fc, input logic fv, input logic [3:0] fp);
    @(negedge clk);
    mode_v[g] = m;
    push_run(g, p, cyc + 1, 1'b1, ps, fc, fv, fp);
    start_v[g] = 1'b1;
    @(negedge clk);
    start_v[g] = 1'b0;
    wait_drain(16 * p + 40);
  endtask

  task automatic chk_zero(input int g, input string tag);
    chk({tag, "_drive"}, {c0_v[g], b0_v[g], a1_v[g], a0_v[g]}, 0);
    chk({tag, "_busy"}, busy_v[g], 0);
    chk({tag, "_done"}, done_v[g], 0);
    chk({tag, "_pass"}, pass_v[g], 0);
    chk({tag, "_fail_count"}, fc_v[g], 0);
    chk({tag, "_fail_valid"}, fv_v[g], 0);
`ifdef LA_OA211_BIST_CAPTURE_EN
    chk({tag, "_fail_pattern"}, fp_v[g], 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    start_v = 3'b000;
    for (int g = 0; g < 3; g++) mode_v[g] = M_IDEAL;
    nreset = 1'b1;
    #1 nreset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) chk_zero(g, $sformatf("reset%0d", g));
    @(negedge clk);
    nreset = 1'b1;

    // Ideal gate, then faulted gates across the three PASSES settings.
    run(0, 1,  M_IDEAL, 1'b1, 8'd0,   1'b0, 4'd0);
    run(0, 1,  M_SA0,   1'b0, 8'd3,   1'b1, 4'd13);
    run(1, 4,  M_SA1,   1'b0, 8'd52,  1'b1, 4'd0);
    run(1, 4,  M_AND,   1'b0, 8'd8,   1'b1, 4'd13);
    run(2, 20, M_SA1,   1'b0, 8'd255, 1'b1, 4'd0);

    // Results hold after the run until the next start.
    repeat (5) @(negedge clk);
    chk("hold_pass2", pass_v[2], 0);
    chk("hold_fc2", fc_v[2], 255);
    chk("hold_fc0", fc_v[0], 3);
    chk("hold_fv1", fv_v[1], 1);

    // Reset during RUN cycle 7 aborts without a done pulse.
    @(negedge clk);
    mode_v[0] = M_IDEAL;
    s = cyc + 1;
    push_run(0, 1, s, 1'b0, 1'b0, 8'd0, 1'b0, 4'd0);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    while (cyc < s + 6) @(negedge clk);
    chk("pre_abort_busy", busy_v[0], 1);
    #2 nreset = 1'b0;
    #1;
    chk_zero(0, "abort");
    chk_zero(2, "abort_other");
    drvq.delete();
    @(negedge clk);
    #2 nreset = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_busy", busy_v[0], 0);
    run(0, 1, M_IDEAL, 1'b1, 8'd0, 1'b0, 4'd0);

    // start re-asserted at RUN cycles 3 and 10 is ignored.
    @(negedge clk);
    s = cyc + 1;
    push_run(0, 1, s, 1'b1, 1'b1, 8'd0, 1'b0, 4'd0);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    while (cyc < s + 2) @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    while (cyc < s + 9) @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_drain(60);
    repeat (20) @(negedge clk);

    // start held high: back-to-back runs with one IDLE cycle between them.
    @(negedge clk);
    s = cyc + 1;
    push_run(0, 1, s,      1'b1, 1'b1, 8'd0, 1'b0, 4'd0);
    push_run(0, 1, s + 18, 1'b1, 1'b1, 8'd0, 1'b0, 4'd0);
    start_v[0] = 1'b1;
    while (cyc < s + 18) @(negedge clk);
    start_v[0] = 1'b0;
    wait_drain(80);
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
